// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: single-outstanding imem requests, redirect handling,
// registered instruction output with a one-entry skid buffer and flush/misalign signalling.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstB,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc,
  output logic        flush_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {StBoot, StReq, StWait, StDrop} state_e;

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        misalign_q, misalign_d;
  logic        rsp_take;

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      state_q      <= StBoot;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      out_valid_q  <= 1'b0;
      out_instr_q  <= 32'h0;
      out_pc_q     <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      flush_cnt_q  <= 3'd0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      flush_cnt_q  <= flush_cnt_d;
      misalign_q   <= misalign_d;
    end
  end

  // Hold off new requests when both the output register and the skid entry are stuck.
  assign imem_req  = (state_q == StReq) & ~redirect_valid
                   & ~(stall & out_valid_q & skid_valid_q);
  assign imem_addr = pc_q;
  assign rsp_take  = (state_q == StWait) & imem_rvalid & ~redirect_valid;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    misalign_d   = 1'b0;
    flush_cnt_d  = (flush_cnt_q != 3'd0) ? flush_cnt_q - 3'd1 : 3'd0;

    if (redirect_valid) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      flush_cnt_d  = FlushLoad;
      misalign_d   = |redirect_pc[1:0];
      // An in-flight request must have its response swallowed before fetching again.
      if ((state_q == StWait && !imem_rvalid) || state_q == StDrop) begin
        state_d = StDrop;
      end else begin
        state_d = StReq;
      end
    end else begin
      case (state_q)
        StBoot: state_d = StReq;
        StReq: begin
          if (imem_req && imem_gnt) begin
            state_d  = StWait;
            req_pc_d = pc_q;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            state_d = StReq;
            pc_d    = pc_q + 32'd4;
          end
        end
        StDrop: begin
          if (imem_rvalid) begin
            state_d = StReq;
          end
        end
        default: state_d = StBoot;
      endcase

      if (!stall) begin
        if (skid_valid_q) begin
          out_valid_d = 1'b1;
          out_instr_d = skid_instr_q;
          out_pc_d    = skid_pc_q;
          if (rsp_take) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = req_pc_q;
          end else begin
            skid_valid_d = 1'b0;
          end
        end else if (rsp_take) begin
          out_valid_d = 1'b1;
          out_instr_d = imem_rdata;
          out_pc_d    = req_pc_q;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (rsp_take) begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_instr_d = imem_rdata;
          out_pc_d    = req_pc_q;
        end else begin
          skid_valid_d = 1'b1;
          skid_instr_d = imem_rdata;
          skid_pc_d    = req_pc_q;
        end
      end
    end
  end

  assign instr_valid = out_valid_q;
  assign instr_o     = out_instr_q;
  assign instr_pc    = out_pc_q;
  assign flush_o     = (flush_cnt_q != 3'd0);
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer: one vector per clock cycle,
// plus a hand-written asynchronous-reset-mid-transaction sequence.
module tb_fetch_sequencer;

  logic        clk;
  logic        rstB;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_o;
  logic [31:0] instr_pc;
  logic        flush_o;
  logic        misalign_o;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk           (clk),
    .rstB          (rstB),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_o       (instr_o),
    .instr_pc      (instr_pc),
    .flush_o       (flush_o),
    .misalign_o    (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        stl;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
    logic        e_fl;
    logic        e_mis;
  } vec_t;

  localparam int NVec = 34;
  vec_t vecs[NVec];

  localparam logic [31:0] D0   = 32'h1111_0000;
  localparam logic [31:0] D4   = 32'h1111_0004;
  localparam logic [31:0] D8   = 32'h1111_0008;
  localparam logic [31:0] DC   = 32'h1111_000C;
  localparam logic [31:0] D100 = 32'h2222_0100;
  localparam logic [31:0] D80  = 32'h3333_0080;
  localparam logic [31:0] DF   = 32'h4444_FFFC;

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic stl,
                              input logic gnt, input logic rv, input logic [31:0] rdata,
                              input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_ipc, input logic [31:0] e_instr,
                              input logic e_fl, input logic e_mis);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.stl = stl; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc;
    v.e_instr = e_instr; v.e_fl = e_fl; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_iv, input logic [31:0] e_ipc,
                           input logic [31:0] e_instr, input logic e_fl, input logic e_mis);
    check({tag, " imem_req"},    32'(imem_req),    32'(e_req));
    check({tag, " imem_addr"},   imem_addr,        e_addr);
    check({tag, " instr_valid"}, 32'(instr_valid), 32'(e_iv));
    check({tag, " instr_pc"},    instr_pc,         e_ipc);
    check({tag, " instr_o"},     instr_o,          e_instr);
    check({tag, " flush_o"},     32'(flush_o),     32'(e_fl));
    check({tag, " misalign_o"},  32'(misalign_o),  32'(e_mis));
  endtask

  task automatic drive(input logic redir, input logic [31:0] rpc, input logic stl,
                       input logic gnt, input logic rv, input logic [31:0] rdata);
    redirect_valid = redir;
    redirect_pc    = rpc;
    stall          = stl;
    imem_gnt       = gnt;
    imem_rvalid    = rv;
    imem_rdata     = rdata;
  endtask

  initial begin
    // Normal fetch: gnt in REQ, rvalid the cycle after.
    vecs[0]  = mk(0, 0, 0, 0, 0, 0,     0, 32'h0,   0, 32'h0, 32'h0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 0, 0,     1, 32'h0,   0, 32'h0, 32'h0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 1, D0,    0, 32'h0,   0, 32'h0, 32'h0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 1, 0, 0,     1, 32'h4,   1, 32'h0, D0,    0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 1, D4,    0, 32'h4,   0, 32'h0, D0,    0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 0, 0,     1, 32'h8,   1, 32'h4, D4,    0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 1, D8,    0, 32'h8,   0, 32'h4, D4,    0, 0);
    // Stall with a response arriving: skid fills, request blocked, then two in order.
    vecs[7]  = mk(0, 0, 1, 1, 0, 0,     1, 32'hC,   1, 32'h8, D8,    0, 0);
    vecs[8]  = mk(0, 0, 1, 0, 1, DC,    0, 32'hC,   1, 32'h8, D8,    0, 0);
    vecs[9]  = mk(0, 0, 1, 1, 0, 0,     0, 32'h10,  1, 32'h8, D8,    0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0,     1, 32'h10,  1, 32'h8, D8,    0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0,     1, 32'h10,  1, 32'hC, DC,    0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0,     1, 32'h10,  0, 32'hC, DC,    0, 0);
    // Redirect in WAIT -> DROP; late response discarded; flush exactly 2 cycles.
    vecs[13] = mk(0, 0, 0, 1, 0, 0,     1, 32'h10,  0, 32'hC, DC,    0, 0);
    vecs[14] = mk(1, 32'h100, 0, 0, 0, 0, 0, 32'h10, 0, 32'hC, DC,   0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0,     0, 32'h100, 0, 32'hC, DC,    1, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0,     0, 32'h100, 0, 32'hC, DC,    1, 0);
    vecs[17] = mk(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 32'h100, 0, 32'hC, DC, 0, 0);
    vecs[18] = mk(0, 0, 0, 1, 0, 0,     1, 32'h100, 0, 32'hC, DC,    0, 0);
    vecs[19] = mk(0, 0, 0, 0, 1, D100,  0, 32'h100, 0, 32'hC, DC,    0, 0);
    // Misaligned redirect, then back-to-back redirects.
    vecs[20] = mk(1, 32'h203, 0, 0, 0, 0, 0, 32'h104, 1, 32'h100, D100, 0, 0);
    vecs[21] = mk(0, 0, 0, 0, 0, 0,     1, 32'h200, 0, 32'h100, D100, 1, 1);
    vecs[22] = mk(1, 32'h40, 0, 0, 0, 0, 0, 32'h200, 0, 32'h100, D100, 1, 0);
    vecs[23] = mk(1, 32'h80, 0, 0, 0, 0, 0, 32'h40,  0, 32'h100, D100, 1, 0);
    vecs[24] = mk(0, 0, 0, 1, 0, 0,     1, 32'h80,  0, 32'h100, D100, 1, 0);
    vecs[25] = mk(0, 0, 0, 0, 1, D80,   0, 32'h80,  0, 32'h100, D100, 1, 0);
    // rvalid in REQ is ignored.
    vecs[26] = mk(0, 0, 0, 0, 1, 32'hBAD0_0BAD, 1, 32'h84, 1, 32'h80, D80, 0, 0);
    // PC wrap at the top of the address space.
    vecs[27] = mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 32'h84, 0, 32'h80, D80, 0, 0);
    vecs[28] = mk(0, 0, 0, 1, 0, 0,     1, 32'hFFFF_FFFC, 0, 32'h80, D80, 1, 0);
    vecs[29] = mk(0, 0, 0, 0, 1, DF,    0, 32'hFFFF_FFFC, 0, 32'h80, D80, 1, 0);
    vecs[30] = mk(0, 0, 0, 0, 0, 0,     1, 32'h0, 1, 32'hFFFF_FFFC, DF, 0, 0);
    // Redirect coinciding with rvalid in WAIT: data dropped, straight back to REQ.
    vecs[31] = mk(0, 0, 0, 1, 0, 0,     1, 32'h0, 0, 32'hFFFF_FFFC, DF, 0, 0);
    vecs[32] = mk(1, 32'h300, 0, 0, 1, 32'h5555_5555, 0, 32'h0, 0, 32'hFFFF_FFFC, DF, 0, 0);
    vecs[33] = mk(0, 0, 0, 0, 0, 0,     1, 32'h300, 0, 32'hFFFF_FFFC, DF, 1, 0);

    rstB = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1 check_all("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    rstB = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      drive(vecs[i].redir, vecs[i].rpc, vecs[i].stl, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv,
                vecs[i].e_ipc, vecs[i].e_instr, vecs[i].e_fl, vecs[i].e_mis);
      @(negedge clk);
    end

    // Reset asserted while a request is outstanding; the late response must be ignored.
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #2 rstB = 1'b0;
    #1 check_all("async_rst", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    rstB = 1'b1;
    drive(0, 0, 0, 0, 1, 32'h6666_6666);
    #1 check("late_rsp boot imem_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    #1 check_all("late_rsp req", 1, 32'h0, 0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1 check_all("late_rsp after", 1, 32'h0, 0, 32'h0, 32'h0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: FLUSH_CYCLES, 2, number of cycles flush_o stays high after a redirect (range 1..7).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rstB  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: redirect_valid  input  1  branch/jump taken (branch unit jmp_occur qualified by decode).
REQ-006 Port: redirect_pc  input  32  redirect target address.
REQ-007 Port: stall  input  1  downstream not accepting; instruction output holds.
REQ-008 Port: imem_req / imem_addr  output  1 / 32  instruction memory request and word address.
REQ-009 Port: imem_gnt  input  1  request accepted this cycle.
REQ-010 Port: imem_rvalid / imem_rdata  input  1 / 32  response; at most one outstanding request.
REQ-011 Port: instr_valid / instr_o / instr_pc  output  1 / 32 / 32  registered instruction to decode, with its PC.
REQ-012 Port: flush_o  output  1  kill younger instructions in IF/ID/EX.
REQ-013 Port: misalign_o  output  1  one-cycle pulse when a redirect target has bits [1:0] != 0.

Function
REQ-014 States: BOOT, REQ, WAIT, DROP; reset enters BOOT; BOOT -> REQ unconditionally on the next edge.
REQ-015 The fetch PC register shall reset to RESET_PC; imem_addr shall always equal the fetch PC.
REQ-016 imem_req = (state==REQ) & !redirect_valid & !(stall & instr_valid & skid_valid), combinational.
REQ-017 REQ: imem_req & imem_gnt -> WAIT, capture request PC; no grant -> stay in REQ with address held.
REQ-018 WAIT: imem_rvalid -> load {rdata, request PC} into the output register when it is empty or !stall, else into the one-entry skid buffer; fetch PC += 4 (32-bit wrap); -> REQ.
REQ-019 When !stall and the skid buffer is full, the skid entry moves to the output register on that edge; order is preserved.
REQ-020 instr_valid clears on an edge with !stall and no new data; while stall=1, instr_valid/instr_o/instr_pc are held unchanged.
REQ-021 Redirect has priority over all other events: fetch PC <= {redirect_pc[31:2],2'b00}; instr_valid and the skid buffer clear on the same edge.
REQ-022 Redirect in BOOT or REQ -> REQ; in WAIT with imem_rvalid the same cycle -> REQ with data discarded; in WAIT without rvalid -> DROP.
REQ-023 DROP: imem_req=0; imem_rvalid -> response discarded, -> REQ; a further redirect in DROP updates the PC and stays in DROP.
REQ-024 flush_o: a counter loads FLUSH_CYCLES on each redirect edge; flush_o=1 while the counter != 0, counting down by 1 per cycle; a redirect during a flush reloads the counter.
REQ-025 misalign_o is registered: high for the one cycle after a redirect edge with redirect_pc[1:0]!=0.
REQ-026 Any imem_rvalid arriving in BOOT or REQ shall be ignored.

Reset
REQ-027 On rstB=0 (asynchronous): state=BOOT, PC=RESET_PC, instr_valid=0, skid empty, flush counter=0, flush_o=0, misalign_o=0, imem_req=0, instr_o=0, instr_pc=0.
REQ-028 Reset asserted mid-transaction abandons any outstanding request; late responses after reset are ignored per REQ-026/REQ-014.

Verification
REQ-029 Reset release, gnt tied 1, rvalid one cycle after gnt -> instr_pc sequence 0x0, 0x4, 0x8 with instr_valid every second cycle; flush_o=0.
REQ-030 Redirect to 0x100 while in WAIT, rvalid 3 cycles later -> that response is discarded, next imem_addr=0x100, flush_o high exactly 2 cycles, instr_valid=0 until the 0x100 response arrives.
REQ-031 stall=1 with instr_valid=1 and a response arriving -> data goes to skid, imem_req=0; stall drops -> two consecutive instructions delivered in PC order, none lost.
REQ-032 redirect_pc=0x203 -> imem_addr=0x200, misalign_o pulses 1 cycle.
REQ-033 Back-to-back redirects 0x40 then 0x80 on consecutive cycles -> fetch from 0x80 only, flush_o high 3 cycles total.
REQ-034 Fetch PC 0xFFFF_FFFC completes -> next imem_addr=0x0000_0000.
